// File: rtl/counter_ctrl.sv
// Sequencing front-end for a 4-bit universal counter: debounced buttons drive
// an IDLE/LOAD/RUN controller that issues load, direction and hold controls.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | counter held, waiting for a load or run press
//   LOAD  | one-cycle load strobe, sw_data captured on entry
//   RUN   | counter enabled once per TICK_DIV clocks, optional limit stop
module counter_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic [3:0] sw_data,
  input  logic       stop_at_limit,
  input  logic [3:0] count,
  output logic [3:0] data,
  output logic       load,
  output logic       incr,
  output logic       pause,
  output logic [1:0] state,
  output logic       limit_hit
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  // Button index: 0 = load, 1 = run, 2 = dir
  logic [2:0] w_btn;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_deb;
  logic [2:0] r_deb_q;
  logic [2:0] r_arm;
  logic [1:0] r_prime;
  logic [3:0] r_cnt [3];
  logic [2:0] w_press;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [3:0] r_data;
  logic       r_incr;
  logic [7:0] r_tick;
  logic       w_at_tick;
  logic       w_limit_stop;

  assign w_btn = {btn_dir, btn_run, btn_load};

  // A button held through reset must be released before it can press again;
  // r_prime waits until the synchronizer reflects post-reset input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_arm   <= '0;
      r_prime <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      r_prime <= {r_prime[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        if (r_prime[1] && !r_s2[i]) r_arm[i] <= 1'b1;
        if (r_s2[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_deb & ~r_deb_q & r_arm;

  assign w_at_tick    = (r_state == S_RUN) && (r_tick == TICK_LAST);
  assign w_limit_stop = w_at_tick && stop_at_limit &&
                        (count == (r_incr ? 4'hF : 4'h0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press[0])      w_next = S_LOAD;
        else if (w_press[1]) w_next = S_RUN;
      end
      S_LOAD:  w_next = S_IDLE;
      S_RUN: begin
        if (w_limit_stop || w_press[1]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    state     = r_state;
    data      = r_data;
    incr      = r_incr;
    load      = (r_state == S_LOAD);
    pause     = ~(w_at_tick && !w_limit_stop);
    limit_hit = w_limit_stop;
  end

  // Tick restarts from zero on every RUN entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 4'h0;
      r_incr <= 1'b1;
      r_tick <= '0;
    end else begin
      if (r_state == S_IDLE && w_press[0]) r_data <= sw_data;
      if (w_press[2]) r_incr <= ~r_incr;
      if (r_state == S_RUN && w_next == S_RUN)
        r_tick <= (r_tick == TICK_LAST) ? 8'd0 : r_tick + 8'd1;
      else
        r_tick <= '0;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: expected outputs are queued per clock cycle and
// compared by a negedge monitor as the cycles arrive.
`timescale 1ns/1ps

module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load, btn_run, btn_dir;
  logic [3:0] sw_data;
  logic       stop_at_limit;
  logic [3:0] count;
  logic [3:0] data;
  logic       load, incr, pause, limit_hit;
  logic [1:0] state;

  counter_ctrl #(.DEB_CYCLES(4), .TICK_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .btn_load(btn_load), .btn_run(btn_run), .btn_dir(btn_dir),
    .sw_data(sw_data), .stop_at_limit(stop_at_limit), .count(count),
    .data(data), .load(load), .incr(incr), .pause(pause),
    .state(state), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] st;
    logic       ld;
    logic [3:0] dat;
    logic       inc;
    logic       pa;
    logic       lh;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
    string name;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] b;      // {dir, run, load}
    int         hold;
    logic [3:0] sw;
    outs_t      e5;
    outs_t      e6;
    outs_t      e7;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic outs_t mk(input logic [1:0] st, input logic ld,
                               input logic [3:0] dat, input logic inc,
                               input logic pa, input logic lh);
    outs_t o;
    o.st = st; o.ld = ld; o.dat = dat; o.inc = inc; o.pa = pa; o.lh = lh;
    return o;
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = {state, load, data, incr, pause, limit_hit};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got st=%b ld=%b data=%h incr=%b pause=%b lh=%b, expected st=%b ld=%b data=%h incr=%b pause=%b lh=%b",
               name, cyc, a.st, a.ld, a.dat, a.inc, a.pa, a.lh,
               e.st, e.ld, e.dat, e.inc, e.pa, e.lh);
    end
  endtask

  task automatic push(input int c, input outs_t o, input string name);
    exp_t e;
    e.cyc = c; e.o = o; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  task automatic set_btns(input logic [2:0] b);
    btn_load = b[0];
    btn_run  = b[1];
    btn_dir  = b[2];
  endtask

  // Run press with a limit armed: stop in the 8th RUN cycle.
  task automatic limit_seq(input string name, input logic [3:0] cnt_v,
                           input logic inc_v, input logic [3:0] dat_v);
    int c, r;
    stop_at_limit = 1'b1;
    count = cnt_v;
    sync(c);
    r = c + 7;
    push(r - 1, mk(2'b00, 0, dat_v, inc_v, 1, 0), {name, "_idle"});
    for (int k = 0; k < 7; k++) push(r + k, mk(2'b10, 0, dat_v, inc_v, 1, 0), {name, "_run"});
    push(r + 7, mk(2'b10, 0, dat_v, inc_v, 1, 1), {name, "_hit"});
    push(r + 8, mk(2'b00, 0, dat_v, inc_v, 1, 0), {name, "_stop"});
    push(r + 9, mk(2'b00, 0, dat_v, inc_v, 1, 0), {name, "_stop2"});
    set_btns(3'b010);
    wait_cyc(c + 8);
    set_btns(3'b000);
    wait_cyc(r + 20);
    stop_at_limit = 1'b0;
  endtask

  initial begin
    int c, r, c2, e, r0;

    rst = 1'b1;
    set_btns(3'b000);
    sw_data = 4'h0;
    stop_at_limit = 1'b0;
    count = 4'h0;

    fork
      begin
        exp_t q;
        forever begin
          @(negedge clk);
          if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
              q = exp_q.pop_front();
              if (q.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", q.name, q.cyc, cyc);
              end else begin
                check(q.name, q.o);
              end
            end
          end
        end
      end
    join_none

    vecs[0] = '{"load_A",     3'b001, 8, 4'hA, mk(0,0,4'h0,1,1,0), mk(1,1,4'hA,1,1,0), mk(0,0,4'hA,1,1,0)};
    vecs[1] = '{"glitch3",    3'b001, 3, 4'h5, mk(0,0,4'hA,1,1,0), mk(0,0,4'hA,1,1,0), mk(0,0,4'hA,1,1,0)};
    vecs[2] = '{"load_min4",  3'b001, 4, 4'h6, mk(0,0,4'hA,1,1,0), mk(1,1,4'h6,1,1,0), mk(0,0,4'h6,1,1,0)};
    vecs[3] = '{"dir_down",   3'b100, 8, 4'hF, mk(0,0,4'h6,1,1,0), mk(0,0,4'h6,0,1,0), mk(0,0,4'h6,0,1,0)};
    vecs[4] = '{"load_dn",    3'b001, 6, 4'h9, mk(0,0,4'h6,0,1,0), mk(1,1,4'h9,0,1,0), mk(0,0,4'h9,0,1,0)};
    vecs[5] = '{"dir_up",     3'b100, 5, 4'hE, mk(0,0,4'h9,0,1,0), mk(0,0,4'h9,1,1,0), mk(0,0,4'h9,1,1,0)};
    vecs[6] = '{"load_run",   3'b011, 8, 4'h3, mk(0,0,4'h9,1,1,0), mk(1,1,4'h3,1,1,0), mk(0,0,4'h3,1,1,0)};
    vecs[7] = '{"run_glitch", 3'b010, 3, 4'h7, mk(0,0,4'h3,1,1,0), mk(0,0,4'h3,1,1,0), mk(0,0,4'h3,1,1,0)};

    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(2'b00, 0, 4'h0, 1, 1, 0));
    rst = 1'b0;
    wait_cyc(cyc + 5);

    for (int i = 0; i < 8; i++) begin
      sync(c);
      sw_data = vecs[i].sw;
      push(c + 6, vecs[i].e5, {vecs[i].name, "@5"});
      push(c + 7, vecs[i].e6, {vecs[i].name, "@6"});
      push(c + 8, vecs[i].e7, {vecs[i].name, "@7"});
      set_btns(vecs[i].b);
      wait_cyc(c + vecs[i].hold);
      set_btns(3'b000);
      wait_cyc(c + 24);
    end

    // RUN with wrap allowed: pause drops every 8th cycle, then a second press stops.
    count = 4'hF;
    sync(c);
    r  = c + 7;
    c2 = c + 41;
    e  = c2 + 7;
    push(r - 1, mk(2'b00, 0, 4'h3, 1, 1, 0), "run_enter");
    for (int k = r; k < e + 4; k++) begin
      if (k < e) push(k, mk(2'b10, 0, 4'h3, 1, (((k - r) % 8) == 7) ? 1'b0 : 1'b1, 0), "run_tick");
      else       push(k, mk(2'b00, 0, 4'h3, 1, 1, 0), "run_exit");
    end
    set_btns(3'b010);
    wait_cyc(c + 8);
    set_btns(3'b000);
    wait_cyc(c2);
    set_btns(3'b010);
    wait_cyc(c2 + 8);
    set_btns(3'b000);
    wait_cyc(e + 10);

    limit_seq("limit_up", 4'hF, 1'b1, 4'h3);

    // Dir press lands in the limit-check cycle; the check sees the old incr.
    stop_at_limit = 1'b1;
    count = 4'hF;
    sync(c);
    r = c + 7;
    push(r + 6, mk(2'b10, 0, 4'h3, 1, 1, 0), "dirlim_pre");
    push(r + 7, mk(2'b10, 0, 4'h3, 1, 1, 1), "dirlim_hit");
    push(r + 8, mk(2'b00, 0, 4'h3, 0, 1, 0), "dirlim_after");
    set_btns(3'b010);
    wait_cyc(c + 8);
    set_btns(3'b100);
    wait_cyc(c + 16);
    set_btns(3'b000);
    wait_cyc(c + 32);
    stop_at_limit = 1'b0;

    limit_seq("limit_dn", 4'h0, 1'b0, 4'h3);

    // Reset mid-RUN with run still held: no press until a release.
    count = 4'h0;
    sync(c);
    r = c + 7;
    push(r, mk(2'b10, 0, 4'h3, 0, 1, 0), "rst_run");
    set_btns(3'b010);
    wait_cyc(r + 3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", mk(2'b00, 0, 4'h0, 1, 1, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = cyc;
    for (int k = r0 + 1; k <= r0 + 15; k++) push(k, mk(2'b00, 0, 4'h0, 1, 1, 0), "rst_held");
    wait_cyc(r0 + 15);
    set_btns(3'b000);
    wait_cyc(r0 + 30);

    sync(c);
    push(c + 6, mk(2'b00, 0, 4'h0, 1, 1, 0), "fresh_idle");
    push(c + 7, mk(2'b10, 0, 4'h0, 1, 1, 0), "fresh_run");
    set_btns(3'b010);
    wait_cyc(c + 8);
    set_btns(3'b000);
    wait_cyc(c + 12);

    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t q;
      q = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never reached", q.name, q.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, number of consecutive stable synchronized samples required to change a debounced button level (legal 1..15).
REQ-002 SHALL have parameter TICK_DIV, default 8, RUN-state period in clocks between count enables (legal 2..255).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_load  input  1  raw asynchronous load button.
REQ-006 SHALL have port btn_run  input  1  raw asynchronous run/stop button.
REQ-007 SHALL have port btn_dir  input  1  raw asynchronous direction-toggle button.
REQ-008 SHALL have port sw_data  input  4  preset value switches, sampled directly, quasi-static.
REQ-009 SHALL have port stop_at_limit  input  1  1 = auto-stop at 4'hF (up) or 4'h0 (down).
REQ-010 SHALL have port count  input  4  feedback from downstream universal counter output.
REQ-011 SHALL have port data  output  4  preset value to counter.
REQ-012 SHALL have port load  output  1  counter load strobe.
REQ-013 SHALL have port incr  output  1  counter direction, 1 = up.
REQ-014 SHALL have port pause  output  1  counter hold, 1 = hold.
REQ-015 SHALL have port state  output  2  FSM state, IDLE=00, LOAD=01, RUN=10.
REQ-016 SHALL have port limit_hit  output  1  one-cycle pulse on auto-stop.

Function
REQ-017 SHALL pass each button through a 2-flop synchronizer (s1, s2) into a debouncer: counter increments on each edge where s2 differs from debounced level, clears when equal; debounced level flips at the edge where counter reaches DEB_CYCLES, counter then clears.
REQ-018 SHALL generate an internal press event as a one-cycle pulse on the debounced level's rising edge; releases generate no event.
REQ-019 SHALL meet this latency: raw input high from edge 0 → debounced level rises at edge DEB_CYCLES+1 → FSM/incr update at edge DEB_CYCLES+2 (edge 6 at default).
REQ-020 SHALL toggle incr on each btn_dir press, in any state.
REQ-021 SHALL transition IDLE→LOAD on load press, capturing sw_data into data at that edge.
REQ-022 SHALL transition IDLE→RUN on run press; on simultaneous load and run press, load wins.
REQ-023 SHALL stay in LOAD exactly one cycle, then return to IDLE unconditionally; presses during LOAD are discarded.
REQ-024 SHALL transition RUN→IDLE on run press; load press in RUN is ignored.
REQ-025 SHALL clear the 8-bit tick counter on RUN entry and increment it each RUN cycle, wrapping TICK_DIV-1→0.
REQ-026 SHALL drive load=1 only in LOAD, else 0.
REQ-027 SHALL drive pause=0 only in RUN with tick==TICK_DIV-1 and no limit stop, else 1 (including LOAD).
REQ-028 SHALL hold data at its last captured value outside LOAD.
REQ-029 SHALL apply a limit stop when in RUN, tick==TICK_DIV-1, stop_at_limit=1 and count==(incr ? 4'hF : 4'h0): pause stays 1, state→IDLE, limit_hit=1 for that one cycle.
REQ-030 SHALL give a run press in the limit-stop cycle no additional effect (result IDLE).
REQ-031 SHALL allow a dir press in the same cycle as a limit check, but the check uses the pre-toggle incr.
REQ-032 SHALL keep the counter wrap-around (F→0, 0→F) as normal behaviour when stop_at_limit=0.

Reset
REQ-033 SHALL, on rst=1, asynchronously force state=IDLE, data=4'h0, incr=1, load=0, pause=1, limit_hit=0, tick=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-034 SHALL, on reset assertion mid-RUN or mid-LOAD, abort immediately with no load pulse, and shall accept no press until a fresh debounced rising edge after release.

Verification
REQ-035 SHALL cover: sw_data=4'hA, btn_load high from edge 0 → load=1 and data=4'hA for exactly one cycle starting edge 6, state 00→01→00.
REQ-036 SHALL cover: btn_load glitch high 3 cycles (DEB_CYCLES=4) → no load pulse, state stays IDLE.
REQ-037 SHALL cover: run press from IDLE, incr=1 → pause=0 once every 8 cycles, first at 8th RUN cycle; second run press → IDLE, pause=1 constant.
REQ-038 SHALL cover: stop_at_limit=1, incr=1, count=4'hF at tick 7 → limit_hit=1 one cycle, state=IDLE, pause stays 1.
REQ-039 SHALL cover: simultaneous load and run press in IDLE → LOAD taken, then IDLE (not RUN).
REQ-040 SHALL cover: rst pulse during RUN → all outputs at reset values within same cycle, incr=1, state=00.
